ksa_shuffle: RTL and testbench

RC4 key-scheduling stage (KSA). It runs after the S-memory has been initialised to S[n]=n and before the PRGA/decrypt stage.
- For i = 0..255: j = j + S[i] + key[i mod KEY_LEN], then swap S[i] and S[j].
- Works in place on the shared 256x8 S-memory through a single read/write port.
- Signals `done` so the PRGA stage can start.

---
 rtl/rc4_pkg.sv | 27 ++
 rtl/ksa_shuffle.sv | 145 ++++++++++++++
 tb/tb_ksa_shuffle.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: byte type, S-memory depth, default key length, stage FSM states.
// Latency: none (types and constants only).
// Backpressure: none.
package rc4_pkg;

    typedef logic [7:0] byte_t;

    localparam int S_DEPTH         = 256;
    localparam int KEY_LEN_DEFAULT = 3;

    // Same encoding style is reused by the PRGA stage.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_RD_I    = 4'd1,
        ST_WAIT_I  = 4'd2,
        ST_LATCH_I = 4'd3,
        ST_CALC_J  = 4'd4,
        ST_RD_J    = 4'd5,
        ST_WAIT_J  = 4'd6,
        ST_LATCH_J = 4'd7,
        ST_WR_J    = 4'd8,
        ST_WR_I    = 4'd9,
        ST_NEXT    = 4'd10,
        ST_DONE    = 4'd11
    } state_e;

endpackage

// File: rtl/ksa_shuffle.sv
// RC4 key schedule: in-place swap pass over the 256-byte S-memory through one RW port.
// Latency: (8 + 2*RD_WAIT) cycles per byte; done rises 2561 cycles after start with RD_WAIT=1.
// Backpressure: none; start is a level request sampled only in IDLE, done holds until start drops.
module ksa_shuffle
    import rc4_pkg::*;
#(
    parameter int KEY_LEN = KEY_LEN_DEFAULT,
    parameter int RD_WAIT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [8*KEY_LEN-1:0] secret_key,
    input  logic [7:0]           q_s,
    output logic [7:0]           address_s,
    output logic [7:0]           data_s,
    output logic                 wren_s,
    output logic                 done
);

    localparam int KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam int WW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

    state_e               r_state;
    state_e               w_next;
    byte_t                r_i;
    byte_t                r_j;
    byte_t                r_s_i;
    byte_t                r_s_j;
    logic [KW-1:0]        r_kidx;
    logic [WW-1:0]        r_wait;
    logic [8*KEY_LEN-1:0] r_key;
    byte_t                w_key_byte;
    byte_t                w_i_nxt;
    byte_t                w_j_nxt;
    logic                 w_wait_end;

    // Key byte select: byte 0 is the most significant byte of the latched key.
    always_comb begin
        w_key_byte = '0;
        for (int k = 0; k < KEY_LEN; k++) begin
            if (r_kidx == KW'(k)) begin
                w_key_byte = r_key[8*(KEY_LEN-1-k) +: 8];
            end
        end
    end

    assign w_wait_end = (r_wait == WW'(RD_WAIT - 1));

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_next = ST_RD_I;
            ST_RD_I:    w_next = (RD_WAIT == 0) ? ST_LATCH_I : ST_WAIT_I;
            ST_WAIT_I:  if (w_wait_end) w_next = ST_LATCH_I;
            ST_LATCH_I: w_next = ST_CALC_J;
            ST_CALC_J:  w_next = ST_RD_J;
            ST_RD_J:    w_next = (RD_WAIT == 0) ? ST_LATCH_J : ST_WAIT_J;
            ST_WAIT_J:  if (w_wait_end) w_next = ST_LATCH_J;
            ST_LATCH_J: w_next = ST_WR_J;
            ST_WR_J:    w_next = ST_WR_I;
            ST_WR_I:    w_next = ST_NEXT;
            ST_NEXT:    w_next = (r_i == 8'hFF) ? ST_DONE : ST_RD_I;
            ST_DONE:    if (!start) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Index updates computed ahead so the registered read address sees the new value.
    always_comb begin
        w_i_nxt = r_i;
        w_j_nxt = r_j;
        if (r_state == ST_IDLE && start) begin
            w_i_nxt = '0;
            w_j_nxt = '0;
        end else if (r_state == ST_CALC_J) begin
            w_j_nxt = r_j + r_s_i + w_key_byte;
        end else if (r_state == ST_NEXT && r_i != 8'hFF) begin
            w_i_nxt = r_i + 8'd1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Datapath: indices, key latch, read captures, wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_i    <= '0;
            r_j    <= '0;
            r_kidx <= '0;
            r_s_i  <= '0;
            r_s_j  <= '0;
            r_wait <= '0;
            r_key  <= '0;
        end else begin
            r_i <= w_i_nxt;
            r_j <= w_j_nxt;
            if (r_state == ST_IDLE && start) begin
                r_key  <= secret_key;
                r_kidx <= '0;
            end
            if (r_state == ST_NEXT && r_i != 8'hFF) begin
                r_kidx <= (r_kidx == KW'(KEY_LEN - 1)) ? '0 : r_kidx + KW'(1);
            end
            if (r_state == ST_LATCH_I) r_s_i <= q_s;
            if (r_state == ST_LATCH_J) r_s_j <= q_s;
            if ((r_state == ST_WAIT_I || r_state == ST_WAIT_J) && w_next == r_state)
                r_wait <= r_wait + WW'(1);
            else
                r_wait <= '0;
        end
    end

    // Registered outputs, decoded from the state being entered so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            address_s <= '0;
            data_s    <= '0;
            wren_s    <= 1'b0;
            done      <= 1'b0;
        end else begin
            wren_s <= (w_next == ST_WR_J) || (w_next == ST_WR_I);
            done   <= (w_next == ST_DONE);
            case (w_next)
                ST_RD_I: address_s <= w_i_nxt;
                ST_RD_J: address_s <= w_j_nxt;
                ST_WR_J: begin
                    address_s <= r_j;
                    data_s    <= r_s_i;
                end
                ST_WR_I: begin
                    address_s <= r_i;
                    data_s    <= r_s_j;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ksa_shuffle.sv
// Bench for ksa_shuffle: registered-address S RAM, KSA reference model, write-stream scoreboard.
// Latency: checks done 2561 cycles after the start-sampled cycle.
// Backpressure: exercises start held high in DONE and start/key toggling mid-run.
module tb_ksa_shuffle;
    import rc4_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [23:0] secret_key = '0;
    logic [7:0]  q_s;
    logic [7:0]  address_s;
    logic [7:0]  data_s;
    logic        wren_s;
    logic        done;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    ksa_shuffle #(.KEY_LEN(3), .RD_WAIT(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .secret_key (secret_key),
        .q_s        (q_s),
        .address_s  (address_s),
        .data_s     (data_s),
        .wren_s     (wren_s),
        .done       (done)
    );

    always #5 clk = ~clk;

    // S RAM with registered read address; mem_init reloads S[n]=n.
    logic [7:0] mem [256];
    logic [7:0] ram_addr = '0;
    logic       mem_init = 1'b0;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else if (wren_s) begin
            mem[address_s] <= data_s;
        end
        ram_addr <= address_s;
    end
    assign q_s = mem[ram_addr];

    // Write monitor.
    int wq_a[$];
    int wq_d[$];
    int wq_t[$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1;
        if (wren_s) begin
            wq_a.push_back(int'(address_s));
            wq_d.push_back(int'(data_s));
            wq_t.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference KSA: final S plus expected (addr,data) write stream.
    int exp_s[256];
    int exp_wa[$];
    int exp_wd[$];
    task automatic build_model(input logic [23:0] key);
        int j, t, kb;
        for (int n = 0; n < 256; n++) exp_s[n] = n;
        exp_wa.delete();
        exp_wd.delete();
        j = 0;
        for (int i = 0; i < 256; i++) begin
            kb = int'((key >> (8 * (2 - (i % 3)))) & 24'hFF);
            j  = (j + exp_s[i] + kb) % 256;
            exp_wa.push_back(j); exp_wd.push_back(exp_s[i]);
            exp_wa.push_back(i); exp_wd.push_back(exp_s[j]);
            t = exp_s[i]; exp_s[i] = exp_s[j]; exp_s[j] = t;
        end
    endtask

    task automatic run_ksa(input logic [23:0] key, input bit hold);
        int lat;
        int bad;
        build_model(key);
        mem_init = 1'b1;
        @(posedge clk); #1;
        mem_init = 1'b0;
        wq_a.delete(); wq_d.delete(); wq_t.delete();
        start = 1'b1;
        secret_key = key;
        @(posedge clk); #1;
        lat = 1;
        while (!done && lat < 6000) begin
            secret_key = 24'($urandom);
            start = hold ? 1'b1 : 1'($urandom % 2);
            @(posedge clk); #1;
            lat++;
        end
        chk("done_seen", done, 1'b1);
        chk("done_lat", lat, 2561);
        chk("wr_count", wq_a.size(), 512);
        if (wq_a.size() == 512) begin
            bad = 0;
            for (int k = 0; k < 512; k++) begin
                if (wq_a[k] != exp_wa[k] || wq_d[k] != exp_wd[k]) begin
                    if (bad < 4) begin
                        chk($sformatf("wr%0d_addr", k), wq_a[k], exp_wa[k]);
                        chk($sformatf("wr%0d_data", k), wq_d[k], exp_wd[k]);
                    end
                    bad++;
                end
            end
            chk("wr_pairs_bad", bad, 0);
            bad = 0;
            for (int k = 0; k < 256; k++) begin
                if (wq_t[2*k+1] - wq_t[2*k] != 1) bad++;
                if (k < 255 && wq_t[2*k+2] - wq_t[2*k] != 10) bad++;
            end
            chk("wr_spacing_bad", bad, 0);
        end
        bad = 0;
        for (int n = 0; n < 256; n++) begin
            if (int'(mem[n]) != exp_s[n]) begin
                if (bad < 4) chk($sformatf("S[%0d]", n), mem[n], exp_s[n]);
                bad++;
            end
        end
        chk("s_final_bad", bad, 0);
        if (!hold) begin
            start = 1'b0;
            @(posedge clk); #1;
            chk("idle_done", done, 1'b0);
        end
    endtask

    initial begin
        int nw;
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", address_s, 8'h00);
        chk("rst_data", data_s, 8'h00);
        chk("rst_wren", wren_s, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
        reset = 1'b0;
        @(posedge clk); #1;

        // All-zero key: i=0 and i=1 are self-swaps, i=2 swaps S[2]/S[3].
        run_ksa(24'h000000, 1'b0);
        if (wq_a.size() >= 6) begin
            chk("k0_i0_wr_addr", wq_a[0], 0);
            chk("k0_i1_wrj_addr", wq_a[2], 1);
            chk("k0_i1_wrj_data", wq_d[2], 1);
            chk("k0_i1_wri_addr", wq_a[3], 1);
            chk("k0_i1_wri_data", wq_d[3], 1);
            chk("k0_i2_wrj_addr", wq_a[4], 3);
            chk("k0_i2_wrj_data", wq_d[4], 2);
            chk("k0_i2_wri_addr", wq_a[5], 2);
            chk("k0_i2_wri_data", wq_d[5], 3);
        end else begin
            chk("k0_early_writes", wq_a.size(), 6);
        end

        run_ksa(24'h000249, 1'b0);

        for (int r = 0; r < 3; r++) run_ksa(24'($urandom), 1'b0);

        // Reset in the middle of a run.
        mem_init = 1'b1;
        @(posedge clk); #1;
        mem_init = 1'b0;
        start = 1'b1;
        secret_key = 24'($urandom);
        @(posedge clk); #1;
        for (int c = 1; c < 500; c++) begin
            start = 1'($urandom % 2);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_addr", address_s, 8'h00);
        chk("mid_rst_data", data_s, 8'h00);
        chk("mid_rst_wren", wren_s, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_state", 32'(dut.r_state), 32'(ST_IDLE));
        reset = 1'b0;
        @(posedge clk); #1;
        run_ksa(24'h000249, 1'b0);

        // start held high after done: stays in DONE with no writes.
        run_ksa(24'($urandom), 1'b1);
        nw = wq_a.size();
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk("hold_done", done, 1'b1);
        end
        chk("hold_no_writes", wq_a.size(), nw);
        start = 1'b0;
        @(posedge clk); #1;
        chk("drop_done", done, 1'b0);
        chk("drop_state", 32'(dut.r_state), 32'(ST_IDLE));
        run_ksa(24'($urandom), 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
